// File: rtl/msrv32_imem_slave.sv
// msrv32_imem_slave: instruction-side bus responder with wait states, error response, preload port; MSRV32_IMEM_WAIT_PROG_EN adds wait_cfg_in
module msrv32_imem_slave #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] i_addr_in,
  input  logic        i_req_in,
  output logic [31:0] instr_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out,
  input  logic        wr_en_in,
  input  logic [31:0] wr_addr_in,
  input  logic [31:0] wr_data_in
`ifdef MSRV32_IMEM_WAIT_PROG_EN
  ,
  input  logic [3:0]  wait_cfg_in
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  logic [31:0] mem [DEPTH];
  state_t state_q, state_d;
  logic ready_q, ready_d, resp_q, resp_d;
  logic [31:0] instr_q, instr_d;
  logic [3:0] cnt_q, cnt_d, wcfg;
  logic [AW-1:0] idx_q, idx_d, a_idx;
  logic accept, valid;
`ifdef MSRV32_IMEM_WAIT_PROG_EN
  assign wcfg = wait_cfg_in;
`else
  assign wcfg = 4'(WAIT_STATES);
`endif
  assign a_idx = i_addr_in[AW+1:2];
  assign accept = ready_q & i_req_in;
  assign valid = i_addr_in[1:0] == 2'b00 && i_addr_in < LIMIT;
  assign instr_out = instr_q;
  assign ahb_ready_out = ready_q;
  assign ahb_resp_out = resp_q;
  // next-state and registered-output decode for the fetch handshake
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    resp_d  = resp_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? S_IDLE : S_WAIT;
        ready_d = cnt_q == 4'd0;
        instr_d = cnt_q == 4'd0 ? mem[idx_q] : instr_q;
      end
      S_ERR1: begin
        state_d = S_ERR2;
        ready_d = 1'b1;
        resp_d  = 1'b1;
      end
      default: begin
        state_d = !accept ? S_IDLE : !valid ? S_ERR1 : wcfg == 4'd0 ? S_IDLE : S_WAIT;
        ready_d = !accept || (valid && wcfg == 4'd0);
        resp_d  = accept && !valid;
        instr_d = !accept ? instr_q : !valid ? NOP_INSTR : wcfg == 4'd0 ? mem[a_idx] : instr_q;
        cnt_d   = wcfg - 4'd1;
        idx_d   = a_idx;
      end
    endcase
  end
  // state and output registers; reset abandons any transfer in flight
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end
  // preload port; same-edge reads see the old word, out-of-range writes are dropped
  always_ff @(posedge clk_in) begin
    if (wr_en_in && wr_addr_in < LIMIT) mem[wr_addr_in[AW+1:2]] <= wr_data_in;
  end
endmodule

// File: tb/tb_msrv32_imem_slave.sv
// tb_msrv32_imem_slave: directed checks of a zero-wait and a three-wait instance sharing stimulus
module tb_msrv32_imem_slave;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0 = 32'h00500093, W1 = 32'h00a00113, W2 = 32'h002081b3;
  logic clk = 1'b0, rst = 1'b0, req = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wr_addr = '0, wr_data = '0;
  logic [31:0] i0, i3;
  logic r0, p0, r3, p3;
  int checks = 0, fails = 0;
`ifdef MSRV32_IMEM_WAIT_PROG_EN
  logic [3:0] wcfg = 4'd3;
`endif
  always #5 clk = ~clk;
  msrv32_imem_slave #(.DEPTH(16), .WAIT_STATES(0)) u0 (
    .clk_in(clk), .rst_in(rst), .i_addr_in(addr), .i_req_in(req),
    .instr_out(i0), .ahb_ready_out(r0), .ahb_resp_out(p0),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data)
`ifdef MSRV32_IMEM_WAIT_PROG_EN
    , .wait_cfg_in(4'd0)
`endif
  );
  msrv32_imem_slave #(.DEPTH(16), .WAIT_STATES(3)) u3 (
    .clk_in(clk), .rst_in(rst), .i_addr_in(addr), .i_req_in(req),
    .instr_out(i3), .ahb_ready_out(r3), .ahb_resp_out(p3),
    .wr_en_in(wr_en), .wr_addr_in(wr_addr), .wr_data_in(wr_data)
`ifdef MSRV32_IMEM_WAIT_PROG_EN
    , .wait_cfg_in(wcfg)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic settle();
    req = 1'b0;
    repeat (6) tick();
  endtask
  task automatic test_reset();
    rst = 1'b0; req = 1'b1; addr = 32'h0;
    repeat (2) tick();
    chk("reset_ready", {31'b0, r0}, 32'd1);
    chk("reset_resp", {31'b0, p0}, 32'd0);
    chk("reset_instr", i0, NOP);
    chk("reset_ready3", {31'b0, r3}, 32'd1);
    req = 1'b0; rst = 1'b1;
    repeat (2) tick();
    chk("idle_ready", {31'b0, r0}, 32'd1);
    chk("idle_resp", {31'b0, p0}, 32'd0);
    chk("idle_instr", i0, NOP);
  endtask
  task automatic test_back_to_back();
    req = 1'b1; addr = 32'h0;
    tick();
    chk("b2b_w0", i0, W0);
    chk("b2b_ready0", {31'b0, r0}, 32'd1);
    addr = 32'h4;
    tick();
    chk("b2b_w1", i0, W1);
    addr = 32'h8;
    tick();
    chk("b2b_w2", i0, W2);
    chk("b2b_ready2", {31'b0, r0}, 32'd1);
    settle();
  endtask
  task automatic test_wait_states();
    int lows = 1;
    req = 1'b1; addr = 32'h4;
    tick();
    chk("wait_ready_low", {31'b0, r3}, 32'd0);
    req = 1'b0;
    for (int i = 0; i < 10 && !r3; i++) begin
      tick();
      if (!r3) lows++;
    end
    chk("wait_low_cycles", 32'(lows), 32'd3);
    chk("wait_instr", i3, W1);
    chk("wait_resp", {31'b0, p3}, 32'd0);
    settle();
  endtask
  task automatic test_errors();
    req = 1'b1; addr = 32'h0000000E;
    tick();
    chk("mis_err1_ready", {31'b0, r0}, 32'd0);
    chk("mis_err1_resp", {31'b0, p0}, 32'd1);
    chk("mis_err1_instr", i0, NOP);
    chk("mis_err1_resp3", {31'b0, p3}, 32'd1);
    req = 1'b0;
    tick();
    chk("mis_err2_ready", {31'b0, r0}, 32'd1);
    chk("mis_err2_resp", {31'b0, p0}, 32'd1);
    chk("mis_err2_ready3", {31'b0, r3}, 32'd1);
    tick();
    chk("mis_after_resp", {31'b0, p0}, 32'd0);
    chk("mis_after_instr", i0, NOP);
    req = 1'b1; addr = 32'd64;
    tick();
    chk("oor_err1_ready", {31'b0, r0}, 32'd0);
    chk("oor_err1_resp", {31'b0, p0}, 32'd1);
    addr = 32'h0;
    tick();
    chk("oor_err2_ready", {31'b0, r0}, 32'd1);
    chk("oor_err2_resp", {31'b0, p0}, 32'd1);
    tick();
    chk("err2_fetch_instr", i0, W0);
    chk("err2_fetch_resp", {31'b0, p0}, 32'd0);
    chk("err2_fetch_ready", {31'b0, r0}, 32'd1);
    settle();
  endtask
  task automatic test_collision();
    req = 1'b1; addr = 32'h8;
    wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    chk("coll_old", i0, W2);
    tick();
    chk("coll_new", i0, 32'hDEADBEEF);
    req = 1'b0;
    for (int i = 0; i < 10 && !r3; i++) tick();
    chk("coll_wait_ready", {31'b0, r3}, 32'd1);
    chk("coll_wait_instr", i3, 32'hDEADBEEF);
    settle();
  endtask
  task automatic test_reset_mid();
    req = 1'b1; addr = 32'h4;
    tick();
    req = 1'b0;
    chk("mid_in_wait", {31'b0, r3}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, r3}, 32'd1);
    chk("mid_rst_instr", i3, NOP);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("mid_idle_ready", {31'b0, r3}, 32'd1);
    chk("mid_idle_instr", i3, NOP);
  endtask
`ifdef MSRV32_IMEM_WAIT_PROG_EN
  task automatic test_prog_wait();
    int lows = 1;
    wcfg = 4'd5; req = 1'b1; addr = 32'h0;
    tick();
    wcfg = 4'd1; req = 1'b0;
    chk("prog_ready_low", {31'b0, r3}, 32'd0);
    for (int i = 0; i < 12 && !r3; i++) begin
      tick();
      if (!r3) lows++;
    end
    chk("prog_low_cycles", 32'(lows), 32'd5);
    chk("prog_instr", i3, W0);
    settle();
  endtask
`endif
  initial begin
    test_reset();
    preload(32'h0, W0);
    preload(32'h4, W1);
    preload(32'h8, W2);
    preload(32'd64, 32'hBAD0BAD0);
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_collision();
    test_reset_mid();
`ifdef MSRV32_IMEM_WAIT_PROG_EN
    test_prog_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/msrv32_imem_slave.md
Name: msrv32_imem_slave

Overview:
- Instruction-side AHB-Lite-style bus responder for the MSRV32 core: answers the fetch address driven by the PC unit, returns the instruction word, and owns the ready handshake the PC unit stalls on.
- Backed by a synchronous word memory with a preload write port for boot/bench loading.
- Supports configurable wait states and a two-cycle error response for bad fetch addresses.

Parameters:
- DEPTH, 1024, memory depth in 32-bit words; legal byte range is 0 .. 4*DEPTH-1.
- WAIT_STATES, 0, fixed wait cycles inserted per fetch (0-15).
- NOP_INSTR, 32'h00000013, word driven on reset and on error responses (ADDI x0,x0,0).

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- i_addr_in  input  32  fetch byte address (address phase).
- i_req_in  input  1  fetch request valid in the address phase.
- instr_out  output  32  fetched instruction word (data phase).
- ahb_ready_out  output  1  transfer complete / slave ready (HREADY).
- ahb_resp_out  output  1  0=OKAY, 1=ERROR (HRESP).
- wr_en_in  input  1  preload write strobe.
- wr_addr_in  input  32  preload byte address, word aligned; bits [1:0] ignored.
- wr_data_in  input  32  preload data word.

Behaviour:
- Reset (rst_in low, async) values:
  - ahb_ready_out=1, ahb_resp_out=0, instr_out=NOP_INSTR.
  - FSM in IDLE, wait counter cleared.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- Address acceptance:
  - An address is accepted on an edge where ahb_ready_out=1 and i_req_in=1.
  - Valid address = i_addr_in[1:0]==0 and i_addr_in < 4*DEPTH.
- Valid fetch, WAIT_STATES=0:
  - On the accept edge, instr_out <= mem[i_addr_in[31:2]]; ahb_ready_out stays 1.
  - Result: one data-phase cycle, back-to-back fetches at full rate.
- Valid fetch, WAIT_STATES=N>0:
  - On the accept edge: go to WAIT, ahb_ready_out <= 0, counter <= N-1, word index latched.
  - Each WAIT edge decrements the counter.
  - On the edge where the counter is 0: instr_out <= mem[latched index], ahb_ready_out <= 1, return to IDLE.
  - Result: ready is low for exactly N cycles.
- Invalid fetch (misaligned or out of range):
  - Accept edge -> ERR1: ahb_ready_out=0, ahb_resp_out=1, instr_out=NOP_INSTR.
  - Next edge -> ERR2: ahb_ready_out=1, ahb_resp_out=1.
  - A new address may be accepted in ERR2; if accepted, the next state follows the normal accept rules, otherwise IDLE with resp=0.
  - Wait states are not applied to errors.
- While ahb_ready_out=0: i_addr_in and i_req_in are ignored.
- i_req_in=0 with ready=1: IDLE; instr_out holds its last value; resp=0.
- Preload write:
  - wr_en_in writes mem[wr_addr_in[31:2]] on the edge; legal in any state.
  - Out-of-range writes are dropped.
  - Same-edge read and write to the same word: the read returns the OLD data (read-before-write).
  - A write to the latched index during WAIT is visible if it lands on an edge before the completing edge.
- Reset asserted mid-WAIT or mid-ERR: the transfer is abandoned immediately; outputs take their reset values.

Optional Feature:
- Macro MSRV32_IMEM_WAIT_PROG_EN.
- Defined:
  - Adds input wait_cfg_in[3:0].
  - The wait count is sampled from wait_cfg_in on each accept edge and overrides WAIT_STATES for that transfer.
  - Changes during a transfer have no effect.
- Undefined: port absent; WAIT_STATES is used for every transfer.

Test Plan:
- Reset/idle: rst_in low while i_req_in=1 -> ready=1, resp=0, instr_out=32'h00000013; after release with i_req_in=0 the outputs hold.
- Back-to-back, WAIT_STATES=0: preload mem[0..2]=32'h00500093, 32'h00a00113, 32'h002081b3; addresses 0, 4, 8 on consecutive cycles -> instr_out equals those words in consecutive cycles; ready stays 1.
- Wait states, WAIT_STATES=3: fetch address 0x4 -> ready low for exactly 3 cycles, then ready=1 with instr_out=32'h00a00113.
- Errors:
  - Fetch 0x0000000E (misaligned) -> one cycle ready=0/resp=1, then ready=1/resp=1, instr_out=NOP.
  - Fetch 4*DEPTH -> same two-cycle error.
  - Fetch 0x0 during ERR2 -> valid data returned next.
- Collisions: preload 32'hDEADBEEF to address 0x8 on the same edge a fetch of 0x8 is accepted (WAIT_STATES=0) -> old word returned; a refetch of 0x8 returns 32'hDEADBEEF.
- Reset mid-transfer / programmable waits:
  - Assert rst_in during WAIT -> ready=1 immediately, FSM in IDLE.
  - With MSRV32_IMEM_WAIT_PROG_EN, wait_cfg_in=5 -> 5 wait cycles.
  - Changing wait_cfg_in to 1 mid-transfer leaves that transfer at 5 wait cycles.
